cr_cceip_64_sa_dump: RTL and testbench

- Reader/drain engine for the 64-entry stats-aggregator (SA) counter bank.
- On request, it drives the SA snap and clear-live controls, waits for the snapshots to settle, then streams all 64 50-bit snapshot values over a 32-bit valid/ready stream for DMA/CSR export.
- It is the sole driver of regs_sa_snap and regs_sa_clear_live.

---
 rtl/cr_cceip_64_sa_dump_pkg.sv | 30 +++
 rtl/cr_cceip_64_sa_dump_if.sv | 32 +++
 rtl/cr_cceip_64_sa_dump_wsel.sv | 32 +++
 rtl/cr_cceip_64_sa_dump.sv | 145 ++++++++++++++
 tb/tb_cr_cceip_64_sa_dump.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cr_cceip_64_sa_dump_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_cceip_64_sa_dump_pkg -- shared constants and FSM encoding for the SA dump
// Revision: 1.0
// ---------------------------------------------------------------------------
package cr_cceip_64_sa_dump_pkg;

    localparam int SA_NUM_CNTRS  = 64;
    localparam int SA_CNT_W      = 50;
    localparam int SA_DATA_W     = 32;
    localparam int SA_SNAP_LAT   = 3;
    localparam int SA_IDX_W      = 7;
    localparam int SA_DUMP_WORDS = 2 * SA_NUM_CNTRS;
    localparam int SA_CNT_HI_W   = SA_CNT_W - SA_DATA_W;

    typedef enum logic [2:0] {
        SA_IDLE = 3'd0,
        SA_SNAP = 3'd1,
        SA_WAIT = 3'd2,
        SA_XFER = 3'd3,
        SA_DONE = 3'd4
    } sa_dump_state_e;

    // Wait counter must hold SNAP_LAT-1 and never collapse to zero width.
    function automatic int sa_wait_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cr_cceip_64_sa_dump_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_cceip_64_sa_dump_if -- valid/ready export stream for the SA dump engine
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cr_cceip_64_sa_dump_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 7
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [IDX_W-1:0]  rd_addr;
    logic              rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_addr,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_addr,
        input  rd_last,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/cr_cceip_64_sa_dump_wsel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_sa_dump_wsel -- picks one counter from the bank and returns its lo/hi word
// Revision: 1.0
// ---------------------------------------------------------------------------
module cr_sa_dump_wsel #(
    parameter int NUM_CNTRS = 64,
    parameter int CNT_W     = 50,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 7
) (
    input  wire logic [IDX_W-1:0]           word_idx_i,
    input  wire logic [NUM_CNTRS*CNT_W-1:0] bank_i,
    output logic      [DATA_W-1:0]          word_o
);

    localparam int HI_W = CNT_W - DATA_W;

    logic [CNT_W-1:0] w_cntr [NUM_CNTRS];
    logic [CNT_W-1:0] w_sel;

    for (genvar k = 0; k < NUM_CNTRS; k++) begin : g_cntr
        assign w_cntr[k] = bank_i[k*CNT_W +: CNT_W];
    end

    // Even word index -> low DATA_W bits, odd -> zero-extended upper bits.
    assign w_sel  = w_cntr[word_idx_i[IDX_W-1:1]];
    assign word_o = word_idx_i[0] ? {{(DATA_W-HI_W){1'b0}}, w_sel[CNT_W-1:DATA_W]}
                                  : w_sel[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/cr_cceip_64_sa_dump.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_cceip_64_sa_dump -- snaps the SA counter bank and streams it out as words
// Revision: 1.0
// ---------------------------------------------------------------------------
module cr_cceip_64_sa_dump
    import cr_cceip_64_sa_dump_pkg::*;
#(
    parameter int NUM_CNTRS = SA_NUM_CNTRS,
    parameter int CNT_W     = SA_CNT_W,
    parameter int DATA_W    = SA_DATA_W,
    parameter int SNAP_LAT  = SA_SNAP_LAT,
    parameter int IDX_W     = SA_IDX_W
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       dump_req,
    input  wire logic                       dump_clear,
    input  wire logic [NUM_CNTRS*CNT_W-1:0] sa_snapshot,
    output logic                            regs_sa_snap,
    output logic                            regs_sa_clear_live,
    output logic                            busy,
    output logic                            done,
    cr_cceip_64_sa_dump_if.master           rd
);

    localparam int                WAIT_W    = sa_wait_w(SNAP_LAT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SNAP_LAT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(2 * NUM_CNTRS - 1);

    sa_dump_state_e    state_q;
    logic              clr_q;
    logic              snap_q;
    logic              clear_live_q;
    logic              busy_q;
    logic              done_q;
    logic [WAIT_W-1:0] wait_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [IDX_W-1:0]  rd_addr_q;
    logic              rd_last_q;

    logic [IDX_W-1:0]  idx_d;
    logic [DATA_W-1:0] word_d;

    // rd_addr_q doubles as the word index; entry to XFER always starts at 0.
    always_comb begin
        idx_d = '0;
        if (state_q == SA_XFER) begin
            idx_d = rd_addr_q + 1'b1;
        end
    end

    cr_sa_dump_wsel #(
        .NUM_CNTRS (NUM_CNTRS),
        .CNT_W     (CNT_W),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_wsel (
        .word_idx_i (idx_d),
        .bank_i     (sa_snapshot),
        .word_o     (word_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SA_IDLE;
            clr_q        <= 1'b0;
            snap_q       <= 1'b0;
            clear_live_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wait_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_addr_q    <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            snap_q       <= 1'b0;
            clear_live_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                SA_IDLE: begin
                    if (dump_req) begin
                        clr_q   <= dump_clear;
                        snap_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SA_SNAP;
                    end
                end
                SA_SNAP: begin
                    // Clear follows the snap by a cycle so the capture wins.
                    clear_live_q <= clr_q;
                    wait_q       <= WAIT_LOAD;
                    state_q      <= SA_WAIT;
                end
                SA_WAIT: begin
                    if (wait_q == '0) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= word_d;
                        rd_addr_q  <= idx_d;
                        rd_last_q  <= (idx_d == LAST_IDX);
                        state_q    <= SA_XFER;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                SA_XFER: begin
                    if (rd.rd_ready) begin
                        if (rd_last_q) begin
                            rd_valid_q <= 1'b0;
                            rd_data_q  <= '0;
                            rd_addr_q  <= '0;
                            rd_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= SA_DONE;
                        end else begin
                            rd_data_q <= word_d;
                            rd_addr_q <= idx_d;
                            rd_last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                SA_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= SA_IDLE;
                end
                default: begin
                    state_q <= SA_IDLE;
                end
            endcase
        end
    end

    assign regs_sa_snap       = snap_q;
    assign regs_sa_clear_live = clear_live_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign rd.rd_valid        = rd_valid_q;
    assign rd.rd_data         = rd_data_q;
    assign rd.rd_addr         = rd_addr_q;
    assign rd.rd_last         = rd_last_q;

endmodule
`default_nettype wire

// File: tb/tb_cr_cceip_64_sa_dump.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cr_cceip_64_sa_dump -- randomized self-checking bench for the SA dump engine
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cr_cceip_64_sa_dump;

    localparam int NC = 64;
    localparam int CW = 50;
    localparam int DW = 32;
    localparam int SL = 3;
    localparam int IW = 7;
    localparam int NW = 2 * NC;

    logic             clk = 1'b0;
    logic             rst;
    logic             dump_req;
    logic             dump_clear;
    logic [NC*CW-1:0] sa_snapshot;
    logic             regs_sa_snap;
    logic             regs_sa_clear_live;
    logic             busy;
    logic             done;
    logic [CW-1:0]    snap_mem [NC];

    int n_chk = 0;
    int n_err = 0;

    cr_cceip_64_sa_dump_if #(.DATA_W(DW), .IDX_W(IW)) rd_if ();

    cr_cceip_64_sa_dump #(
        .NUM_CNTRS (NC),
        .CNT_W     (CW),
        .DATA_W    (DW),
        .SNAP_LAT  (SL),
        .IDX_W     (IW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dump_req           (dump_req),
        .dump_clear         (dump_clear),
        .sa_snapshot        (sa_snapshot),
        .regs_sa_snap       (regs_sa_snap),
        .regs_sa_clear_live (regs_sa_clear_live),
        .busy               (busy),
        .done               (done),
        .rd                 (rd_if)
    );

    always #5 clk = ~clk;

    for (genvar k = 0; k < NC; k++) begin : g_bank
        assign sa_snapshot[k*CW +: CW] = snap_mem[k];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: word 2k is the low 32 bits of counter k, word 2k+1 its upper bits.
    function automatic logic [DW-1:0] exp_word(input int i);
        logic [CW-1:0] v;
        v = snap_mem[i / 2];
        if (i % 2 == 0) return v[DW-1:0];
        return DW'(v >> DW);
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_snap"},  64'(regs_sa_snap), 64'(0));
        check_val({tag, "_clr"},   64'(regs_sa_clear_live), 64'(0));
        check_val({tag, "_busy"},  64'(busy), 64'(0));
        check_val({tag, "_done"},  64'(done), 64'(0));
        check_val({tag, "_valid"}, 64'(rd_if.rd_valid), 64'(0));
        check_val({tag, "_data"},  64'(rd_if.rd_data), 64'(0));
        check_val({tag, "_addr"},  64'(rd_if.rd_addr), 64'(0));
        check_val({tag, "_last"},  64'(rd_if.rd_last), 64'(0));
    endtask

    task automatic run_dump(input bit clr, input int stall_pct, input bit hold, input int abort_at);
        int            c;
        int            exp_idx;
        bit            prev_stall;
        bit            rdy;
        logic [DW-1:0] prev_data;
        logic [IW-1:0] prev_addr;
        c          = 1;
        exp_idx    = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_addr  = '0;
        dump_req   = 1'b1;
        dump_clear = clr;
        step();
        if (!hold) begin
            dump_req   = 1'b0;
            dump_clear = 1'($urandom);
        end
        while (exp_idx < NW && c < 4000) begin
            check_val("snap", 64'(regs_sa_snap), 64'(c == 1));
            check_val("clear_live", 64'(regs_sa_clear_live), 64'(clr && c == 2));
            check_val("busy", 64'(busy), 64'(1));
            check_val("done_early", 64'(done), 64'(0));
            check_val("valid", 64'(rd_if.rd_valid), 64'(c >= 2 + SL));
            if (rd_if.rd_valid) begin
                if (prev_stall) begin
                    check_val("stall_data", 64'(rd_if.rd_data), 64'(prev_data));
                    check_val("stall_addr", 64'(rd_if.rd_addr), 64'(prev_addr));
                end
                check_val("addr", 64'(rd_if.rd_addr), 64'(exp_idx));
                check_val("data", 64'(rd_if.rd_data), 64'(exp_word(exp_idx)));
                check_val("last", 64'(rd_if.rd_last), 64'(exp_idx == NW - 1));
            end
            rdy = ($urandom_range(99) >= stall_pct);
            if (abort_at >= 0 && rd_if.rd_valid && rd_if.rd_addr == IW'(abort_at)) begin
                rd_if.rd_ready = 1'b0;
                rst            = 1'b1;
                dump_req       = 1'b0;
                step();
                rst = 1'b0;
                check_all_zero("abort");
                step();
                check_val("abort_idle_valid", 64'(rd_if.rd_valid), 64'(0));
                check_val("abort_idle_busy", 64'(busy), 64'(0));
                return;
            end
            rd_if.rd_ready = rdy;
            if (rd_if.rd_valid && rdy) exp_idx++;
            prev_stall = rd_if.rd_valid && !rdy;
            prev_data  = rd_if.rd_data;
            prev_addr  = rd_if.rd_addr;
            step();
            c++;
        end
        check_val("timeout", 64'(exp_idx), 64'(NW));
        check_val("done", 64'(done), 64'(1));
        check_val("done_busy", 64'(busy), 64'(1));
        check_val("done_valid", 64'(rd_if.rd_valid), 64'(0));
        if (stall_pct == 0) check_val("done_cycle", 64'(c), 64'(2 + SL + NW));
        step();
        check_val("post_busy", 64'(busy), 64'(0));
        check_val("post_done", 64'(done), 64'(0));
        check_val("post_snap", 64'(regs_sa_snap), 64'(0));
        step();
        check_val("resnap", 64'(regs_sa_snap), 64'(hold));
        if (hold) begin
            dump_req = 1'b0;
            rst      = 1'b1;
            step();
            rst = 1'b0;
            check_all_zero("resnap_rst");
        end
    endtask

    initial begin
        rst            = 1'b1;
        dump_req       = 1'b0;
        dump_clear     = 1'b0;
        rd_if.rd_ready = 1'b0;
        for (int k = 0; k < NC; k++) snap_mem[k] = CW'(50'h3_0000_0000_0000 + k);
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        run_dump(1'b0, 0, 1'b0, -1);
        run_dump(1'b1, 0, 1'b0, -1);

        for (int k = 0; k < NC; k++) snap_mem[k] = 50'h3FFFF_FFFFFFFF;
        run_dump(1'b0, 50, 1'b0, -1);

        for (int k = 0; k < NC; k++) snap_mem[k] = CW'({$urandom, $urandom});
        run_dump(1'b1, 30, 1'b1, -1);

        for (int k = 0; k < NC; k++) snap_mem[k] = CW'({$urandom, $urandom});
        run_dump(1'b0, 40, 1'b0, 40);
        run_dump(1'b0, 20, 1'b0, -1);

        rst      = 1'b1;
        dump_req = 1'b1;
        step();
        rst      = 1'b0;
        dump_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("rst_req_snap", 64'(regs_sa_snap), 64'(0));
            check_val("rst_req_busy", 64'(busy), 64'(0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
